// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT datapath sequencers.
package dct_pkg;

  localparam int DCT_N = 8;

  // Last sample / op index within one 8-point vector.
  localparam logic [2:0] LAST_IDX = 3'(DCT_N - 1);

  // Result index ranges: sums come first, then differences.
  localparam logic [2:0] SUM_IDX_FIRST  = 3'd0;
  localparam logic [2:0] SUM_IDX_LAST   = 3'd3;
  localparam logic [2:0] DIFF_IDX_FIRST = 3'd4;
  localparam logic [2:0] DIFF_IDX_LAST  = 3'd7;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } dct_state_t;

  // Mirror partner of sample j in the first butterfly: 7 - j.
  function automatic logic [2:0] mirror_idx(input logic [1:0] j);
    return LAST_IDX - {1'b0, j};
  endfunction

endpackage

// File: rtl/dct_sample_buf.sv
// 8-entry sample register file: one write port, two combinational read ports.
module dct_sample_buf
  import dct_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [2:0]    wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    rd_idx_a,
  input  logic [2:0]    rd_idx_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] mem [DCT_N];

  // Sample storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];

endmodule

// File: rtl/dct_stage1_seq.sv
// First butterfly stage sequencer for the 8-point DCT. Buffers one vector,
// then drives a shared external adder for 8 cycles: four sums x[k]+x[7-k]
// (out_idx 0..3) followed by four differences x[k]-x[7-k] (out_idx 4..7).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in LOAD. out_valid, once raised, stays
// high with out_data/out_idx frozen until out_ready is seen; a new result may
// be registered in the same cycle the previous one is taken.
module dct_stage1_seq
  import dct_pkg::*;
#(
  parameter  int DW = 9,
  localparam int OW = DW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [OW-1:0] add_a,
  output logic [OW-1:0] add_b,
  output logic          add_sub,
  input  logic [OW-1:0] add_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          busy
);

  dct_state_t    state;
  dct_state_t    state_nxt;
  logic [2:0]    wr_idx;
  logic [2:0]    k;
  logic [1:0]    j;
  logic          accept;
  logic          capture;
  logic [DW-1:0] x_lo;
  logic [DW-1:0] x_hi;

  assign j       = k[1:0];
  assign accept  = (state == LOAD) && in_valid;
  assign capture = (state == COMPUTE) && (!out_valid || out_ready);

  dct_sample_buf #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .we        (accept),
    .wr_idx    (wr_idx),
    .wr_data   (in_data),
    .rd_idx_a  ({1'b0, j}),
    .rd_idx_b  (mirror_idx(j)),
    .rd_data_a (x_lo),
    .rd_data_b (x_hi)
  );

  // FSM state register; busy is the externally visible copy of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the adder operand / handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && (wr_idx == LAST_IDX)) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        busy    = 1'b1;
        add_a   = {x_lo[DW-1], x_lo};
        add_b   = {x_hi[DW-1], x_hi};
        add_sub = (k >= DIFF_IDX_FIRST);
        if (capture && (k == DIFF_IDX_LAST)) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Write pointer for the sample buffer; wraps after the 8th accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
    end else if (accept) begin
      wr_idx <= wr_idx + 3'd1;
    end
  end

  // Op counter; advances only when a result is captured, so it holds on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (capture) begin
      k <= k + 3'd1;
    end
  end

  // Output register: capture the adder result, hold it until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= add_sum;
      out_idx   <= k;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
